snax_hwpe_tcdm_stream_reader: RTL and testbench

//  Strided read streamer acting as HWPE TCDM master. It sits directly upstream of the HWPE-to-reqrsp bridge.
//  It issues LEN word reads at START, START+STRIDE, ... and collects in-order r_data into an internal FIFO.
//  The FIFO drains to a valid/ready output stream consumed by the accelerator datapath.

---
 rtl/snax_hwpe_tcdm_stream_reader.sv | 166 ++++++++++++++++
 tb/tb_snax_hwpe_tcdm_stream_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/snax_hwpe_tcdm_stream_reader.sv
// Strided TCDM read streamer: issues LEN word reads at START + k*STRIDE as an
// HWPE TCDM master, buffers in-order responses in a small FIFO and drains them
// to a valid/ready stream. Credit-based issue keeps the FIFO from overflowing.
module snax_hwpe_tcdm_stream_reader #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int LenWidth  = 16,
    parameter int FifoDepth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   cfg_addr_i,
    input  logic [AddrWidth-1:0]   cfg_stride_i,
    input  logic [LenWidth-1:0]    cfg_len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   tcdm_req_o,
    input  logic                   tcdm_gnt_i,
    output logic [31:0]            tcdm_add_o,
    output logic                   tcdm_wen_o,
    output logic [DataWidth/8-1:0] tcdm_be_o,
    output logic [DataWidth-1:0]   tcdm_data_o,
    input  logic [DataWidth-1:0]   tcdm_r_data_i,
    input  logic                   tcdm_r_valid_i,
    output logic                   strm_valid_o,
    input  logic                   strm_ready_i,
    output logic [DataWidth-1:0]   strm_data_o
);

    localparam int CntW = $clog2(FifoDepth + 1);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d, stride_q, stride_d;
    logic [LenWidth-1:0]    len_q, len_d, issued_q, issued_d, popped_q, popped_d;
    logic [CntW-1:0]        outstanding_q, outstanding_d, count_q, count_d;
    logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic                   req_hold_q, req_hold_d, done_q, done_d;
    logic [DataWidth-1:0]   mem_q [FifoDepth];
    logic [DataWidth-1:0]   mem_d [FifoDepth];

    logic credit, hs, rsp, pop, last_pop, start_ok;

    // Room for one more word counting both buffered and in-flight reads.
    assign credit   = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CntW+1)'(FifoDepth);
    assign hs       = tcdm_req_o & tcdm_gnt_i;
    // Responses with nothing in flight (e.g. after a mid-transfer reset) are dropped.
    assign rsp      = tcdm_r_valid_i && (outstanding_q != '0);
    assign pop      = (count_q != '0) && strm_ready_i;
    assign last_pop = pop && (state_q != IDLE) && (popped_q == len_q - LenWidth'(1));
    assign start_ok = (state_q == IDLE) && start_i;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && cfg_len_i != '0) state_d = ISSUE;
            ISSUE: begin
                if (last_pop)                                     state_d = IDLE;
                else if (hs && issued_q + LenWidth'(1) == len_q)  state_d = DRAIN;
            end
            DRAIN:   if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM / datapath outputs. A raised request is held until granted.
    always_comb begin
        busy_o       = (state_q != IDLE);
        done_o       = done_q;
        tcdm_req_o   = (state_q == ISSUE) && (req_hold_q || ((issued_q < len_q) && credit));
        tcdm_add_o   = 32'(addr_q);
        tcdm_wen_o   = 1'b1;
        tcdm_be_o    = '1;
        tcdm_data_o  = '0;
        strm_valid_o = (count_q != '0);
        strm_data_o  = mem_q[rptr_q];
    end

    // Address/counter/FIFO next-state computation.
    always_comb begin
        addr_d        = addr_q;
        stride_d      = stride_q;
        len_d         = len_q;
        issued_d      = issued_q;
        popped_d      = popped_q;
        outstanding_d = outstanding_q;
        count_d       = count_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        mem_d         = mem_q;
        req_hold_d    = tcdm_req_o && !tcdm_gnt_i;
        done_d        = last_pop || (start_ok && cfg_len_i == '0);

        if (start_ok) begin
            addr_d   = cfg_addr_i;
            stride_d = cfg_stride_i;
            len_d    = cfg_len_i;
            issued_d = '0;
            popped_d = '0;
        end
        if (hs) begin
            issued_d = issued_q + LenWidth'(1);
            addr_d   = addr_q + stride_q;
        end
        case ({hs, rsp})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (rsp) begin
            mem_d[wptr_q] = tcdm_r_data_i;
            wptr_d = (wptr_q == PtrW'(FifoDepth - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d   = (rptr_q == PtrW'(FifoDepth - 1)) ? '0 : rptr_q + PtrW'(1);
            popped_d = popped_q + LenWidth'(1);
        end
        case ({rsp, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Datapath registers; asynchronous reset clears everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q        <= '0;
            stride_q      <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            req_hold_q    <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
        end else begin
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            popped_q      <= popped_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            req_hold_q    <= req_hold_d;
            done_q        <= done_d;
            mem_q         <= mem_d;
        end
    end

endmodule

// File: tb/tb_snax_hwpe_tcdm_stream_reader.sv
// Directed bench for the strided TCDM stream reader. A behavioural TCDM slave
// grants one cycle after a request and returns rdata = address one cycle after
// the grant; a monitor logs grants, stream beats and done pulses.
module tb_snax_hwpe_tcdm_stream_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] cfg_addr_i = '0, cfg_stride_i = '0;
    logic [15:0] cfg_len_i = '0;
    logic        busy_o, done_o, tcdm_req_o, tcdm_wen_o, strm_valid_o;
    logic        tcdm_gnt_i = 1'b0, tcdm_r_valid_i = 1'b0, strm_ready_i = 1'b1;
    logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i = '0, strm_data_o;
    logic [3:0]  tcdm_be_o;

    int unsigned n_chk = 0, n_pass = 0;
    int unsigned done_cnt = 0, req_cnt = 0;
    bit          rsp_en = 1'b1, allow_stray = 1'b0, wait_f = 1'b0;
    logic [31:0] adds[$], got[$], rspq[$];

    snax_hwpe_tcdm_stream_reader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .cfg_addr_i(cfg_addr_i), .cfg_stride_i(cfg_stride_i), .cfg_len_i(cfg_len_i),
        .busy_o(busy_o), .done_o(done_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .strm_valid_o(strm_valid_o), .strm_ready_i(strm_ready_i), .strm_data_o(strm_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // TCDM slave: respond to earlier grants first, then grant a waiting request.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rsp_en && rspq.size() > 0) begin
                tcdm_r_valid_i = 1'b1;
                tcdm_r_data_i  = rspq.pop_front();
            end else begin
                tcdm_r_valid_i = 1'b0;
                tcdm_r_data_i  = '0;
            end
            if (tcdm_req_o && wait_f && rst_ni) begin
                tcdm_gnt_i = 1'b1;
                rspq.push_back(tcdm_add_o);
            end else begin
                tcdm_gnt_i = 1'b0;
            end
            wait_f = tcdm_req_o && !tcdm_gnt_i;
        end
    end

    // Monitor: sample settled values well before the next rising edge.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (tcdm_req_o) req_cnt++;
            if (tcdm_req_o && tcdm_gnt_i) adds.push_back(tcdm_add_o);
            if (strm_valid_o && strm_ready_i) got.push_back(strm_data_o);
            if (done_o) done_cnt++;
            if (rst_ni && tcdm_r_valid_i && !allow_stray)
                assert (dut.outstanding_q != 0) else $error("r_valid with nothing outstanding");
        end
    end

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] s, input logic [15:0] l);
        @(negedge clk_i);
        adds.delete(); got.delete();
        done_cnt = 0; req_cnt = 0;
        cfg_addr_i = a; cfg_stride_i = s; cfg_len_i = l; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk_i);
        chk({tag, "_done_once"}, done_cnt, 32'd1);
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_logs(input string tag, input logic [31:0] a, input logic [31:0] s, input int l);
        logic [31:0] e;
        chk({tag, "_nadd"}, adds.size(), l);
        chk({tag, "_nstrm"}, got.size(), l);
        for (int i = 0; i < l; i++) begin
            e = a + 32'(i) * s;
            if (i < adds.size()) chk($sformatf("%s_add%0d", tag, i), adds[i], e);
            if (i < got.size())  chk($sformatf("%s_dat%0d", tag, i), got[i], e);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_req"}, 32'(tcdm_req_o), 0);
        chk({tag, "_add"}, tcdm_add_o, 0);
        chk({tag, "_wen"}, 32'(tcdm_wen_o), 1);
        chk({tag, "_be"}, 32'(tcdm_be_o), 32'hF);
        chk({tag, "_wdata"}, tcdm_data_o, 0);
        chk({tag, "_svalid"}, 32'(strm_valid_o), 0);
        chk({tag, "_sdata"}, strm_data_o, 0);
    endtask

    initial begin
        int n;
        #3 check_reset("rst");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: basic strided read, first request one cycle after start
        start_xfer(32'h100, 32'd4, 16'd4);
        chk("t1_first_req", 32'(tcdm_req_o), 1);
        chk("t1_first_add", tcdm_add_o, 32'h100);
        chk("t1_busy", 32'(busy_o), 1);
        wait_done("t1");
        check_logs("t1", 32'h100, 32'd4, 4);

        // 2: stalled consumer limits grants to FIFO depth
        strm_ready_i = 1'b0;
        start_xfer(32'h1000, 32'd4, 16'd8);
        repeat (30) @(negedge clk_i);
        chk("t2_ngrant", adds.size(), 4);
        chk("t2_req_low", 32'(tcdm_req_o), 0);
        chk("t2_svalid", 32'(strm_valid_o), 1);
        chk("t2_head", strm_data_o, 32'h1000);
        strm_ready_i = 1'b1;
        wait_done("t2");
        check_logs("t2", 32'h1000, 32'd4, 8);

        // 3: negative stride wraps through zero
        start_xfer(32'h4, 32'hFFFF_FFFC, 16'd3);
        wait_done("t3");
        check_logs("t3", 32'h4, 32'hFFFF_FFFC, 3);

        // 4: zero-length transfer
        start_xfer(32'h500, 32'd4, 16'd0);
        chk("t4_done", 32'(done_o), 1);
        chk("t4_busy", 32'(busy_o), 0);
        repeat (10) @(negedge clk_i);
        chk("t4_noreq", req_cnt, 0);
        chk("t4_done_once", done_cnt, 1);

        // 5: reset mid-transfer with two responses pending
        rsp_en = 1'b0;
        start_xfer(32'h300, 32'd4, 16'd6);
        n = 0;
        while (adds.size() < 2 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("t5_two_grants", adds.size(), 2);
        @(negedge clk_i);
        #1 rst_ni = 1'b0;
        allow_stray = 1'b1;
        #1 check_reset("t5rst");
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        rsp_en = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("t5_late_dropped", 32'(got.size()), 0);
        chk("t5_svalid", 32'(strm_valid_o), 0);
        chk("t5_busy", 32'(busy_o), 0);
        allow_stray = 1'b0;
        start_xfer(32'h400, 32'd8, 16'd3);
        wait_done("t5new");
        check_logs("t5new", 32'h400, 32'd8, 3);

        // 6: start while busy is ignored
        start_xfer(32'h200, 32'd8, 16'd5);
        @(negedge clk_i);
        cfg_addr_i = 32'h9000; cfg_stride_i = 32'd16; cfg_len_i = 16'd2; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("t6_busy", 32'(busy_o), 1);
        wait_done("t6");
        check_logs("t6", 32'h200, 32'd8, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
